// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants, state encoding and hazard helper for the pipeline control
package pipeline_pkg;

    localparam logic [1:0] TUSE_NONE       = 2'd3;
    localparam logic       MD_MULT         = 1'b0;
    localparam logic       MD_DIV          = 1'b1;
    localparam int         MULT_CYCLES_DEF = 5;
    localparam int         DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // One producer/consumer pair: the value is still in flight when needed sooner than it is ready.
    function automatic logic src_hazard(
        input logic       we,
        input logic [4:0] a3,
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [1:0] tnew
    );
        return we && (a3 != 5'd0) && (a3 == src) && (tuse < tnew);
    endfunction

endpackage

// File: rtl/md_busy_seq.sv
// rtl/md_busy_seq.sv - mult/div busy-window sequencer with remaining-cycle count and sticky restart error
module md_busy_seq
    import pipeline_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       md_start,
    input  logic       md_type,
    output logic       md_busy,
    output logic [3:0] md_count,
    output logic       md_err
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    md_state_e  state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = BUSY;
                    count_d = (md_type == MD_DIV) ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                // A restart while busy is flagged but never disturbs the running countdown.
                if (md_start) begin
                    err_d = 1'b1;
                end
                count_d = count_q - 4'd1;
                if (count_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        md_busy  = (state_q == BUSY);
        md_count = count_q;
        md_err   = err_q;
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - Tuse/Tnew and mult/div stall decision with saturating stall-cycle counter
module hazard_stall_ctrl
    import pipeline_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_TuseRs,
    input  logic [1:0]  D_TuseRt,
    input  logic        D_isMD,
    input  logic        E_RegWrite,
    input  logic [4:0]  E_RegA3,
    input  logic [1:0]  E_Tnew,
    input  logic        M_RegWrite,
    input  logic [4:0]  M_RegA3,
    input  logic [1:0]  M_Tnew,
    input  logic        E_mdStart,
    input  logic        E_mdType,
    output logic        stall,
    output logic        mdBusy,
    output logic [3:0]  mdCount,
    output logic        mdErr,
    output logic [31:0] stallCnt
);

    logic        stall_data;
    logic        stall_md;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    md_busy_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_seq (
        .clk      (clk),
        .rst_n    (reset),
        .md_start (E_mdStart),
        .md_type  (E_mdType),
        .md_busy  (mdBusy),
        .md_count (mdCount),
        .md_err   (mdErr)
    );

    always_comb begin
        stall_data = src_hazard(E_RegWrite, E_RegA3, D_rs, D_TuseRs, E_Tnew)
                   | src_hazard(E_RegWrite, E_RegA3, D_rt, D_TuseRt, E_Tnew)
                   | src_hazard(M_RegWrite, M_RegA3, D_rs, D_TuseRs, M_Tnew)
                   | src_hazard(M_RegWrite, M_RegA3, D_rt, D_TuseRt, M_Tnew);
        // The mult/div start in E already occupies HI/LO, before the sequencer reports busy.
        stall_md   = D_isMD && (E_mdStart || mdBusy);
        stall      = stall_data || stall_md;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl against a behavioural model
module tb_hazard_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_RegA3, M_RegA3;
    logic [1:0]  D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
    logic        D_isMD, E_RegWrite, M_RegWrite, E_mdStart, E_mdType;
    logic        stall, mdBusy, mdErr;
    logic [3:0]  mdCount;
    logic [31:0] stallCnt;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int      m_rem = 0;
    bit      m_err = 1'b0;
    longint  m_cnt = 0;

    hazard_stall_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt), .D_isMD(D_isMD),
        .E_RegWrite(E_RegWrite), .E_RegA3(E_RegA3), .E_Tnew(E_Tnew),
        .M_RegWrite(M_RegWrite), .M_RegA3(M_RegA3), .M_Tnew(M_Tnew),
        .E_mdStart(E_mdStart), .E_mdType(E_mdType),
        .stall(stall), .mdBusy(mdBusy), .mdCount(mdCount), .mdErr(mdErr), .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_stall();
        int src[2];
        int tuse[2];
        bit s;
        src[0] = int'(D_rs);      src[1] = int'(D_rt);
        tuse[0] = int'(D_TuseRs); tuse[1] = int'(D_TuseRt);
        s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (E_RegWrite && E_RegA3 != 0 && int'(E_RegA3) == src[i] && tuse[i] < int'(E_Tnew)) s = 1'b1;
            if (M_RegWrite && M_RegA3 != 0 && int'(M_RegA3) == src[i] && tuse[i] < int'(M_Tnew)) s = 1'b1;
        end
        if (D_isMD && (E_mdStart || m_rem > 0)) s = 1'b1;
        return s;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem = 0;
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            if (model_stall() && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_rem == 0) begin
                if (E_mdStart) m_rem = E_mdType ? DIV_N : MULT_N;
            end else begin
                if (E_mdStart) m_err = 1'b1;
                m_rem--;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",    64'(stall),    64'(model_stall()));
            chk("mdBusy",   64'(mdBusy),   64'(m_rem != 0));
            chk("mdCount",  64'(mdCount),  64'(m_rem));
            chk("mdErr",    64'(mdErr),    64'(m_err));
            chk("stallCnt", 64'(stallCnt), 64'(m_cnt));
        end
    end

    task automatic clear_inputs();
        D_rs = 0; D_rt = 0; D_TuseRs = 2'd3; D_TuseRt = 2'd3; D_isMD = 0;
        E_RegWrite = 0; E_RegA3 = 0; E_Tnew = 0;
        M_RegWrite = 0; M_RegA3 = 0; M_Tnew = 0;
        E_mdStart = 0; E_mdType = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        #12;
        chk("rst_mdBusy",   64'(mdBusy),   64'd0);
        chk("rst_mdCount",  64'(mdCount),  64'd0);
        chk("rst_mdErr",    64'(mdErr),    64'd0);
        chk("rst_stallCnt", 64'(stallCnt), 64'd0);
        reset = 1'b1;
        chk_en = 1'b1;
        next();

        // Load-use from E
        E_RegWrite = 1; E_RegA3 = 8; E_Tnew = 2; D_rs = 8; D_TuseRs = 1;
        #1 chk("loaduse_stall", 64'(stall), 64'd1);
        E_Tnew = 1;
        #1 chk("loaduse_fwd", 64'(stall), 64'd0);
        clear_inputs();
        next();

        // Register zero never stalls
        M_RegWrite = 1; M_RegA3 = 0; M_Tnew = 2; D_rt = 0; D_TuseRt = 0;
        #1 chk("zero_reg", 64'(stall), 64'd0);
        M_RegA3 = 5; D_rt = 5;
        #1 chk("reg5_stall", 64'(stall), 64'd1);
        clear_inputs();
        next();

        // Mult window
        E_mdStart = 1; E_mdType = 0; D_isMD = 1;
        #1 chk("mult_start_stall", 64'(stall), 64'd1);
        next();
        E_mdStart = 0;
        for (int k = 5; k >= 1; k--) begin
            #1;
            chk("mult_count", 64'(mdCount), 64'(k));
            chk("mult_busy",  64'(mdBusy),  64'd1);
            chk("mult_stall", 64'(stall),   64'd1);
            next();
        end
        #1;
        chk("mult_done_count", 64'(mdCount), 64'd0);
        chk("mult_done_busy",  64'(mdBusy),  64'd0);
        chk("mult_done_stall", 64'(stall),   64'd0);
        clear_inputs();
        next();

        // Div with illegal restart at count 6
        E_mdStart = 1; E_mdType = 1;
        next();
        E_mdStart = 0;
        #1 chk("div_load", 64'(mdCount), 64'd10);
        for (int g = 0; g < 20 && mdCount != 4'd6; g++) next();
        chk("div_reach6", 64'(mdCount), 64'd6);
        E_mdStart = 1;
        next();
        E_mdStart = 0;
        #1;
        chk("div_err",         64'(mdErr),   64'd1);
        chk("div_no_reload",   64'(mdCount), 64'd5);
        for (int j = 5; j >= 1; j--) begin
            chk("div_tail_busy", 64'(mdBusy), 64'd1);
            next();
        end
        #1;
        chk("div_end_busy", 64'(mdBusy), 64'd0);
        chk("div_err_held", 64'(mdErr),  64'd1);
        next();

        // Asynchronous reset mid-div
        E_mdStart = 1; E_mdType = 1;
        next();
        E_mdStart = 0;
        for (int g = 0; g < 20 && mdCount != 4'd4; g++) next();
        chk("div_reach4", 64'(mdCount), 64'd4);
        #1 reset = 1'b0;
        #1;
        chk("arst_busy",     64'(mdBusy),   64'd0);
        chk("arst_count",    64'(mdCount),  64'd0);
        chk("arst_err",      64'(mdErr),    64'd0);
        chk("arst_stallcnt", 64'(stallCnt), 64'd0);
        next();
        reset = 1'b1;

        // Stall counter and saturation
        E_RegWrite = 1; E_RegA3 = 8; E_Tnew = 2; D_rs = 8; D_TuseRs = 0;
        repeat (7) next();
        #1 chk("stallcnt_7", 64'(stallCnt), 64'd7);
        clear_inputs();
        next();
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        m_cnt = 64'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        #1 chk("stallcnt_preload", 64'(stallCnt), 64'hFFFF_FFFE);
        E_RegWrite = 1; E_RegA3 = 8; E_Tnew = 2; D_rs = 8; D_TuseRs = 0;
        repeat (3) next();
        #1 chk("stallcnt_sat", 64'(stallCnt), 64'hFFFF_FFFF);
        clear_inputs();
        reset = 1'b0;
        next();
        reset = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            D_rs       = 5'($urandom_range(0, 3));
            D_rt       = 5'($urandom_range(0, 3));
            D_TuseRs   = 2'($urandom_range(0, 3));
            D_TuseRt   = 2'($urandom_range(0, 3));
            D_isMD     = ($urandom_range(0, 3) == 0);
            E_RegWrite = 1'($urandom_range(0, 1));
            E_RegA3    = 5'($urandom_range(0, 3));
            E_Tnew     = 2'($urandom_range(0, 2));
            M_RegWrite = 1'($urandom_range(0, 1));
            M_RegA3    = 5'($urandom_range(0, 3));
            M_Tnew     = 2'($urandom_range(0, 2));
            E_mdStart  = ($urandom_range(0, 5) == 0);
            E_mdType   = 1'($urandom_range(0, 1));
            next();
        end
        clear_inputs();
        next();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
